// File: rtl/switch_axi_writer_if.sv
// AXI4-Lite bus bundle between switch_axi_writer (master) and the LED
// register slave.
//   AW channel : awaddr, awvalid, awready, awprot
//   W  channel : wdata, wvalid, wready, wstrb
//   B  channel : bresp, bvalid, bready
//   AR channel : araddr, arvalid, arready, arprot
//   R  channel : rdata, rvalid, rready, rresp
interface switch_axi_writer_if #(
  parameter int unsigned AW = 7
);
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [2:0]    awprot;
  logic [31:0]   wdata;
  logic          wvalid;
  logic [3:0]    wstrb;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [2:0]    arprot;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [1:0]    rresp;
  logic          rready;

  modport master (
    output awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
           araddr, arvalid, arprot, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rvalid, rresp
  );

  modport slave (
    input  awaddr, awvalid, awprot, wdata, wvalid, wstrb, bready,
           araddr, arvalid, arprot, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rvalid, rresp
  );
endinterface

// File: rtl/switch_axi_writer.sv
// AXI4-Lite master that mirrors the board slide switches into the LED
// register: switches are synchronised, debounced as a whole vector, and each
// accepted new value is written to LED_ADDR and read back for verification.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   switches    : raw asynchronous switch inputs
//   busy        : 1 while an AXI transaction is in progress
//   err_count   : saturating count of BRESP/RRESP errors and readback mismatches
//   m_axi       : AXI4-Lite master port (switch_axi_writer_if.master)
module switch_axi_writer #(
  parameter int unsigned AW              = 7,
  parameter int unsigned LED_ADDR        = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [15:0]          switches,
  output logic                 busy,
  output logic [7:0]           err_count,
  switch_axi_writer_if.master  m_axi
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WRESP,
    READ,
    RRESP
  } state_t;

  state_t        state;
  logic [15:0]   sync1, sync2;
  logic [15:0]   candidate, stable;
  logic [CW-1:0] db_count;
  logic [15:0]   last_sent, data;
  logic          awvalid, wvalid, bready, arvalid, rready;
  logic          aw_done, w_done;
  logic          aw_fin, w_fin;
  logic          unused_rdata_hi;

  // Two-flop synchroniser on the whole bus.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switches;
      sync2 <= sync1;
    end
  end

  // Whole-vector debounce: any bit change restarts the count; once the count
  // reaches its limit it holds there and keeps reloading stable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      candidate <= '0;
      stable    <= '0;
      db_count  <= '0;
    end else if (sync2 != candidate) begin
      candidate <= sync2;
      db_count  <= '0;
    end else if (db_count == CNT_MAX) begin
      stable    <= candidate;
    end else begin
      db_count  <= db_count + 1'b1;
    end
  end

  // A channel counts as finished if it completed earlier or completes now.
  assign aw_fin = aw_done | (awvalid & m_axi.awready);
  assign w_fin  = w_done  | (wvalid  & m_axi.wready);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == '1) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      busy      <= 1'b0;
      err_count <= '0;
      last_sent <= '0;
      data      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stable != last_sent) begin
            data      <= stable;
            last_sent <= stable;
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            busy      <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          if (awvalid && m_axi.awready) awvalid <= 1'b0;
          if (wvalid && m_axi.wready)   wvalid  <= 1'b0;
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WRESP;
          end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
          end
        end
        WRESP: begin
          if (m_axi.bvalid && bready) begin
            bready <= 1'b0;
            if (m_axi.bresp != 2'b00) begin
              err_count <= sat_inc(err_count);
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              arvalid <= 1'b1;
              state   <= READ;
            end
          end
        end
        READ: begin
          if (arvalid && m_axi.arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RRESP;
          end
        end
        RRESP: begin
          if (m_axi.rvalid && rready) begin
            rready <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
            if (m_axi.rresp != 2'b00 || m_axi.rdata[15:0] != data)
              err_count <= sat_inc(err_count);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axi.awaddr  = AW'(LED_ADDR);
  assign m_axi.awvalid = awvalid;
  assign m_axi.awprot  = '0;
  assign m_axi.wdata   = {16'h0000, data};
  assign m_axi.wvalid  = wvalid;
  assign m_axi.wstrb   = '1;
  assign m_axi.bready  = bready;
  assign m_axi.araddr  = AW'(LED_ADDR);
  assign m_axi.arvalid = arvalid;
  assign m_axi.arprot  = '0;
  assign m_axi.rready  = rready;

  assign unused_rdata_hi = ^m_axi.rdata[31:16];

endmodule

// File: tb/tb_switch_axi_writer.sv
module tb_switch_axi_writer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [15:0] switches = '0;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  switch_axi_writer_if #(.AW(7)) axi ();

  switch_axi_writer #(
    .AW(7),
    .LED_ADDR(0),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .switches(switches),
    .busy(busy),
    .err_count(err_count),
    .m_axi(axi)
  );

  // ---------------- LED register slave with configurable behaviour --------
  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic        rd_ovr_en = 1'b0;
  logic [15:0] rd_ovr = '0;

  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata, wdata_lat;
  logic [15:0] leds;
  logic        aw_got, w_got, ar_got;
  int unsigned aw_c, w_c, b_c;

  always @(posedge clk) begin
    if (!resetn) begin
      s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
      s_arready <= 1'b0; s_rvalid <= 1'b0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0; wdata_lat <= '0;
      leds <= '0; aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_c <= 0; w_c <= 0; b_c <= 0;
    end else begin
      if (s_awready && axi.awvalid) begin
        s_awready <= 1'b0; aw_got <= 1'b1; aw_c <= 0;
      end else if (axi.awvalid && !aw_got && !s_awready) begin
        if (aw_c >= aw_delay) s_awready <= 1'b1; else aw_c <= aw_c + 1;
      end
      if (s_wready && axi.wvalid) begin
        s_wready <= 1'b0; w_got <= 1'b1; w_c <= 0; wdata_lat <= axi.wdata;
      end else if (axi.wvalid && !w_got && !s_wready) begin
        if (w_c >= w_delay) s_wready <= 1'b1; else w_c <= w_c + 1;
      end
      if (s_bvalid && axi.bready) begin
        s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (aw_got && w_got && !s_bvalid) begin
        if (b_c >= b_delay) begin
          s_bvalid <= 1'b1; s_bresp <= bresp_cfg; b_c <= 0;
          if (bresp_cfg == 2'b00) leds <= wdata_lat[15:0];
        end else b_c <= b_c + 1;
      end
      if (s_arready && axi.arvalid) begin
        s_arready <= 1'b0; ar_got <= 1'b1;
      end else if (axi.arvalid && !ar_got && !s_arready) begin
        s_arready <= 1'b1;
      end
      if (s_rvalid && axi.rready) begin
        s_rvalid <= 1'b0; ar_got <= 1'b0;
      end else if (ar_got && !s_rvalid) begin
        s_rvalid <= 1'b1; s_rresp <= rresp_cfg;
        s_rdata <= rd_ovr_en ? {16'h0000, rd_ovr} : {16'h0000, leds};
      end
    end
  end

  assign axi.awready = s_awready;
  assign axi.wready  = s_wready;
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = s_bresp;
  assign axi.arready = s_arready;
  assign axi.rvalid  = s_rvalid;
  assign axi.rresp   = s_rresp;
  assign axi.rdata   = s_rdata;

  // ---------------- bus monitor (samples between active edges) -----------
  logic [31:0] wr_log [0:1023];
  int          wr_n = 0, aw_n = 0, ar_n = 0, rd_n = 0;
  int          proto_n = 0, aw_alone_n = 0, same_hs_n = 0;
  logic [6:0]  awaddr_seen = '0, araddr_seen = '0;
  logic [3:0]  wstrb_seen = '0;
  logic [31:0] rdata_seen = '0;
  logic        p_awv = 1'b0, p_awhs = 1'b0, p_wv = 1'b0, p_whs = 1'b0;
  logic [6:0]  p_awaddr = '0;
  logic [31:0] p_wdata = '0;

  always @(negedge clk) begin
    if (!resetn) begin
      p_awv <= 1'b0; p_awhs <= 1'b0; p_wv <= 1'b0; p_whs <= 1'b0;
    end else begin
      // A VALID left pending must stay high with stable payload; a completed
      // one must drop on the next cycle.
      if ((p_awv && !p_awhs && (!axi.awvalid || axi.awaddr != p_awaddr)) ||
          (p_wv && !p_whs && (!axi.wvalid || axi.wdata != p_wdata)) ||
          (p_awhs && axi.awvalid) || (p_whs && axi.wvalid))
        proto_n <= proto_n + 1;
      p_awv <= axi.awvalid; p_awhs <= axi.awvalid && axi.awready;
      p_wv  <= axi.wvalid;  p_whs  <= axi.wvalid && axi.wready;
      p_awaddr <= axi.awaddr; p_wdata <= axi.wdata;
      if (axi.awvalid && axi.awready) begin
        aw_n <= aw_n + 1; awaddr_seen <= axi.awaddr;
      end
      if (axi.wvalid && axi.wready) begin
        wr_log[wr_n] <= axi.wdata; wr_n <= wr_n + 1; wstrb_seen <= axi.wstrb;
      end
      if (axi.awvalid && axi.awready && axi.wvalid && axi.wready)
        same_hs_n <= same_hs_n + 1;
      if (!axi.awvalid && axi.wvalid) aw_alone_n <= aw_alone_n + 1;
      if (axi.arvalid && axi.arready) begin
        ar_n <= ar_n + 1; araddr_seen <= axi.araddr;
      end
      if (axi.rvalid && axi.rready) begin
        rd_n <= rd_n + 1; rdata_seen <= axi.rdata;
      end
    end
  end

  // ---------------- reference model state ---------------------------------
  logic [15:0] model_last = '0;
  int          model_err = 0;

  // Wait for debounce plus any transactions, then for a quiet bus.
  task automatic settle(input string name);
    int unsigned n = 0;
    int unsigned quiet = 0;
    repeat (12) @(negedge clk);
    while (quiet < 3 && n < 2000) begin
      @(negedge clk);
      n++;
      if (busy) quiet = 0; else quiet++;
    end
    checks++;
    if (quiet < 3) begin
      failures++;
      $display("FAIL %s_timeout: busy=%0b still set, required idle", name, busy);
    end
  endtask

  task automatic test_reset();
    int aw0;
    resetn = 1'b0; switches = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 000000",
               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, busy});
    end
    resetn = 1'b1;
    aw0 = aw_n;
    repeat (20) @(negedge clk);
    checks++;
    if (aw_n != aw0 || axi.awvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_aw: aw=%0d awvalid=%b required none", aw_n - aw0, axi.awvalid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b required 0", busy);
    end
    checks++;
    if (err_count !== 8'd0) begin
      failures++; $display("FAIL reset_err: got %0d required 0", err_count);
    end
  endtask

  task automatic test_single_write();
    int w0 = wr_n, ar0 = ar_n, r0 = rd_n;
    switches = 16'hA5A5;
    settle("single");
    checks++;
    if (wr_n - w0 != 1 || wr_log[w0] !== 32'h0000A5A5) begin
      failures++;
      $display("FAIL single_wdata: writes=%0d data=%h required 1 x 0000a5a5", wr_n - w0, wr_log[w0]);
    end
    checks++;
    if (awaddr_seen !== 7'd0 || wstrb_seen !== 4'hF) begin
      failures++;
      $display("FAIL single_addr_strb: addr=%h strb=%h required 00 f", awaddr_seen, wstrb_seen);
    end
    checks++;
    if (ar_n - ar0 != 1 || rd_n - r0 != 1 || araddr_seen !== 7'd0) begin
      failures++;
      $display("FAIL single_read: ar=%0d r=%0d araddr=%h required 1 1 00", ar_n - ar0, rd_n - r0, araddr_seen);
    end
    checks++;
    if (leds !== 16'hA5A5 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL single_leds_err: leds=%h err=%0d required a5a5 0", leds, err_count);
    end
  endtask

  task automatic test_glitch();
    int w0;
    switches = 16'h0000;
    settle("glitch_pre");
    w0 = wr_n;
    switches = 16'h0001;
    repeat (2) @(negedge clk);
    switches = 16'h0000;
    repeat (20) @(negedge clk);
    checks++;
    if (wr_n != w0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_ignored: writes=%0d busy=%b required 0 0", wr_n - w0, busy);
    end
    switches = 16'h0001;
    repeat (10) @(negedge clk);
    settle("glitch_hold");
    checks++;
    if (wr_n - w0 != 1 || wr_log[w0] !== 32'h00000001) begin
      failures++;
      $display("FAIL glitch_hold: writes=%0d data=%h required 1 x 00000001", wr_n - w0, wr_log[w0]);
    end
  endtask

  task automatic test_backpressure();
    int w0 = wr_n, p0 = proto_n, a0 = aw_alone_n, s0;
    aw_delay = 0; w_delay = 6; b_delay = 3;
    switches = 16'h5A5A;
    settle("bp");
    checks++;
    if (aw_alone_n == a0) begin
      failures++; $display("FAIL bp_aw_alone: cycles=%0d required >0", aw_alone_n - a0);
    end
    checks++;
    if (proto_n != p0) begin
      failures++; $display("FAIL bp_protocol: violations=%0d required 0", proto_n - p0);
    end
    checks++;
    if (wr_n - w0 != 1 || wr_log[w0] !== 32'h00005A5A || leds !== 16'h5A5A || err_count !== 8'(model_err)) begin
      failures++;
      $display("FAIL bp_result: writes=%0d data=%h leds=%h err=%0d required 1 00005a5a 5a5a %0d",
               wr_n - w0, wr_log[w0], leds, err_count, model_err);
    end
    w_delay = 0; b_delay = 0;
    s0 = same_hs_n; p0 = proto_n;
    switches = 16'h1111;
    settle("same");
    checks++;
    if (same_hs_n - s0 != 1 || proto_n != p0) begin
      failures++;
      $display("FAIL same_cycle_hs: joint=%0d violations=%0d required 1 0", same_hs_n - s0, proto_n - p0);
    end
  endtask

  task automatic test_errors();
    int ar0;
    bresp_cfg = 2'b11;
    ar0 = ar_n;
    switches = 16'h7777;
    settle("decerr");
    model_err = model_err + 1;
    checks++;
    if (err_count !== 8'(model_err) || ar_n != ar0) begin
      failures++;
      $display("FAIL decerr: err=%0d ar=%0d required %0d 0", err_count, ar_n - ar0, model_err);
    end
    bresp_cfg = 2'b00; rd_ovr_en = 1'b1; rd_ovr = 16'h1234;
    switches = 16'h00FF;
    settle("mismatch");
    model_err = model_err + 1;
    checks++;
    if (err_count !== 8'(model_err)) begin
      failures++; $display("FAIL rd_mismatch: err=%0d required %0d", err_count, model_err);
    end
    rd_ovr_en = 1'b0; bresp_cfg = 2'b10;
    for (int unsigned i = 0; i < 300; i++) begin
      switches = 16'(i + 16'h0100);
      settle("sat");
      model_err = (model_err >= 255) ? 255 : model_err + 1;
    end
    checks++;
    if (err_count !== 8'd255 || model_err != 255) begin
      failures++; $display("FAIL err_saturate: err=%0d required 255", err_count);
    end
    bresp_cfg = 2'b00;
  endtask

  task automatic test_midtxn_change();
    int w0 = wr_n;
    int unsigned n = 0;
    b_delay = 25;
    switches = 16'h0F0F;
    while (!axi.bready && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!axi.bready) begin
      failures++; $display("FAIL mid_wresp_timeout: bready=%b required 1", axi.bready);
    end
    switches = 16'hF0F0;
    settle("mid");
    checks++;
    if (wr_n - w0 != 2 || wr_log[w0] !== 32'h00000F0F || wr_log[w0+1] !== 32'h0000F0F0) begin
      failures++;
      $display("FAIL mid_sequence: writes=%0d first=%h second=%h required 2 00000f0f 0000f0f0",
               wr_n - w0, wr_log[w0], wr_log[w0+1]);
    end
    checks++;
    if (leds !== 16'hF0F0 || err_count !== 8'(model_err)) begin
      failures++;
      $display("FAIL mid_result: leds=%h err=%0d required f0f0 %0d", leds, err_count, model_err);
    end
    b_delay = 0;
  endtask

  task automatic test_reset_mid();
    int unsigned n = 0;
    int w0;
    aw_delay = 30; w_delay = 30;
    switches = 16'h3C3C;
    while (!axi.awvalid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (!axi.awvalid) begin
      failures++; $display("FAIL rstmid_aw_timeout: awvalid=%b required 1", axi.awvalid);
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, busy} !== 6'b0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: got %b err=%0d required 000000 0",
               {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready, busy}, err_count);
    end
    model_err = 0;
    @(negedge clk);
    aw_delay = 0; w_delay = 0;
    w0 = wr_n;
    resetn = 1'b1;
    settle("rstmid");
    checks++;
    if (wr_n - w0 != 1 || wr_log[w0] !== 32'h00003C3C) begin
      failures++;
      $display("FAIL rstmid_rewrite: writes=%0d data=%h required 1 00003c3c", wr_n - w0, wr_log[w0]);
    end
    model_last = 16'h3C3C;
  endtask

  task automatic test_random();
    for (int unsigned it = 0; it < 25; it++) begin
      logic [15:0] v;
      logic be, re, mm;
      int w0, exp_n;
      v = 16'($urandom);
      if ($urandom_range(0, 4) == 0) v = model_last;
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay = $urandom_range(0, 3);
      be = ($urandom_range(0, 5) == 0);
      re = ($urandom_range(0, 5) == 0);
      mm = ($urandom_range(0, 5) == 0);
      bresp_cfg = be ? 2'b10 : 2'b00;
      rresp_cfg = re ? 2'b10 : 2'b00;
      rd_ovr_en = mm; rd_ovr = v ^ 16'h0001;
      w0 = wr_n;
      switches = 16'($urandom);
      repeat ($urandom_range(1, 2)) @(negedge clk);
      switches = v;
      settle("rand");
      exp_n = (v != model_last) ? 1 : 0;
      if (exp_n == 1) begin
        if (be || re || mm) model_err = (model_err >= 255) ? 255 : model_err + 1;
        model_last = v;
      end
      checks++;
      if (wr_n - w0 != exp_n || (exp_n == 1 && wr_log[w0] !== {16'h0000, v})) begin
        failures++;
        $display("FAIL rand_write[%0d]: writes=%0d data=%h required %0d x %h",
                 it, wr_n - w0, wr_log[w0], exp_n, {16'h0000, v});
      end
      checks++;
      if (err_count !== 8'(model_err)) begin
        failures++;
        $display("FAIL rand_err[%0d]: err=%0d required %0d", it, err_count, model_err);
      end
    end
    bresp_cfg = 2'b00; rresp_cfg = 2'b00; rd_ovr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_glitch();
    test_backpressure();
    test_errors();
    test_midtxn_change();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_axi_writer.md
Name: switch_axi_writer

Overview:
- AXI4-Lite master that feeds the 16-bit LED register slave from board slide switches.
- Synchronises and debounces the 16 switch inputs.
- On every debounced change, writes the new value to the LED register, then reads it back to verify.
- Write-response errors, read-response errors and readback mismatches are counted for debug.

Parameters:
AW, 7, AXI address width; must match the downstream slave.
LED_ADDR, 0, byte address of the LED register.
DEBOUNCE_CYCLES, 1000000, cycles the synchronised switch vector must stay unchanged before it is accepted (minimum 2).

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
switches  in  16  raw asynchronous switch inputs
busy  out  1  1 = AXI transaction in progress
err_count  out  8  saturating error counter
M_AXI_AWADDR  out  AW  write address
M_AXI_AWVALID  out  1
M_AXI_AWREADY  in  1
M_AXI_AWPROT  out  3  constant 0
M_AXI_WDATA  out  32
M_AXI_WVALID  out  1
M_AXI_WSTRB  out  4  constant 4'hF
M_AXI_WREADY  in  1
M_AXI_BRESP  in  2
M_AXI_BVALID  in  1
M_AXI_BREADY  out  1
M_AXI_ARADDR  out  AW  read address
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_ARPROT  out  3  constant 0
M_AXI_RDATA  in  32
M_AXI_RVALID  in  1
M_AXI_RRESP  in  2
M_AXI_RREADY  out  1

Behaviour:
- Reset (resetn=0 at clk edge):
  - State goes to IDLE.
  - All VALID/READY outputs are 0; busy=0; err_count=0.
  - Synchroniser, candidate, stable, last_sent and data registers are all 0.
  - Reset mid-transaction aborts immediately with no completion; the slave shares the same reset.
- Synchroniser: 2 flops on the whole switches bus.
- Debounce (whole vector):
  - If sync != candidate: candidate<=sync, counter<=0.
  - Else, if counter == DEBOUNCE_CYCLES-1: stable<=candidate, counter held.
  - Else: counter+1.
  - Any bit toggling restarts the count.
- FSM states: IDLE, WRITE, WRESP, READ, RRESP.
- IDLE:
  - If stable != last_sent: data<=stable, last_sent<=stable, AWVALID<=1, WVALID<=1, go to WRITE.
  - AWVALID is seen high 1 cycle after stable changes.
- WRITE:
  - AWADDR=LED_ADDR; WDATA={16'h0,data}.
  - Each VALID drops on the cycle after its own handshake (VALID&READY); AW and W may complete in either order or together.
  - When both are done, BREADY<=1 and go to WRESP.
- WRESP:
  - On BVALID&BREADY: BREADY<=0.
  - If BRESP != 0: err_count+1, go to IDLE (no readback).
  - Else: ARVALID<=1, go to READ.
- READ: ARADDR=LED_ADDR. On ARVALID&ARREADY: ARVALID<=0, RREADY<=1, go to RRESP.
- RRESP:
  - On RVALID&RREADY: RREADY<=0, go to IDLE.
  - If RRESP != 0 or RDATA[15:0] != data: err_count+1.
- Error count:
  - Saturates at 255; never wraps.
  - At most +1 per transaction.
- busy = (state != IDLE), registered.
- Switch changes during a transaction:
  - data is frozen for the whole transaction.
  - The new stable value is handled on return to IDLE; intermediate values may be skipped, and only the latest stable value is written.
- Equal values: if stable returns to last_sent before IDLE is reached, no transaction is issued.
- No timeouts: the FSM waits indefinitely for slave handshakes.
- VALID never deasserts before its handshake completes; address and data stay stable while VALID is high.

Test Plan:
All tests use DEBOUNCE_CYCLES=4.
1. Reset with switches=16'h0000, hold 20 cycles -> no AWVALID, busy=0, err_count=0.
2. switches=16'hA5A5, slave always ready -> exactly one write (AWADDR=0, WDATA=32'h0000A5A5, WSTRB=F), then one read. RDATA=A5A5 gives err_count=0; the LED slave's leds=16'hA5A5.
3. Glitch: switches toggles 16'h0001 for 2 cycles, then back to 0 -> no transaction. Hold 16'h0001 for 10 cycles -> one write of 1.
4. Back-pressure:
   - Stimulus: WREADY delayed 5 cycles after AWREADY, BVALID delayed 3 cycles.
   - Required: AWVALID drops alone, WVALID stays high until its handshake, data stable throughout, and the transaction completes OK.
   - Separate case, AW and W handshake in the same cycle: both VALIDs drop together.
5. Errors:
   - BRESP=DECERR -> err_count=1, no AR issued.
   - RDATA[15:0]=16'h1234 vs data=16'h00FF -> err_count=2.
   - Force 300 errors -> err_count holds at 255.
6. Mid-transaction events:
   - switches change 16'h0F0F -> 16'hF0F0 during WRESP -> the first transaction completes with 0F0F, then a second write of F0F0.
   - resetn=0 asserted while in WRITE -> next cycle all VALIDs 0, busy=0.
